// File: rtl/booth_mul_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package booth_mul_pkg;

    localparam int DEFAULT_OP_W    = 64;
    localparam int DEFAULT_TIMEOUT = 100;

    // Arbiter sequencing states; encoding is visible on debug taps, keep it fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_t;

    // States of the shared multiplier core, for reference by models and monitors.
    typedef enum logic [1:0] {
        CORE_INIT = 2'd0,
        CORE_EXEC = 2'd1,
        CORE_DONE = 2'd2
    } core_state_t;

    // Requester index to one-hot grant vector.
    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr.sv
// Two-way round-robin grant: the requester not granted last time wins a tie.
// Latency: purely combinational.
// Backpressure: none; the parent decides when a grant is consumed.
module rr_arbiter2
    import booth_mul_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic pri;

    assign pri = ~last;

    // Favour the other requester; fall back to the last one if it is alone.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (req[pri]) begin
            gnt    = onehot2(pri);
            gnt_id = pri;
        end else if (req[last]) begin
            gnt    = onehot2(last);
            gnt_id = last;
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier core between two requesters with a tagged response.
// Latency: grant in IDLE is combinational; response ~68 cycles after accept (core bound).
// Backpressure: one op in flight; req_ready low until the response is taken.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int OP_W    = DEFAULT_OP_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_multiplier,
    input  logic [2*OP_W-1:0]   req_multiplicand,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [2*OP_W-1:0]   resp_result,
    output logic                resp_error,
    output logic                mul_op_clear,
    output logic                mul_op_start,
    output logic [OP_W-1:0]     mul_multiplier,
    output logic [OP_W-1:0]     mul_multiplicand,
    input  logic                mul_op_done,
    input  logic [2*OP_W-1:0]   mul_result,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             rr_ptr;      // requester that currently holds priority
    logic [CNT_W-1:0] wd_cnt;
    logic [1:0]       gnt;
    logic             gnt_id;
    logic             req_fire;
    logic             wd_expired;

    rr_arbiter2 u_rr (
        .req    (req_valid),
        .last   (~rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Grants are only offered in IDLE and never while reset is held.
    assign req_ready  = (state == ST_IDLE && reset_n) ? gnt : 2'b00;
    assign req_fire   = |req_ready;
    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    // Next-state and core control pulses.
    always_comb begin
        state_nxt    = state;
        mul_op_clear = 1'b0;
        mul_op_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_fire) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                mul_op_clear = 1'b1;
                state_nxt    = ST_START;
            end
            ST_START: begin
                mul_op_start = 1'b1;
                state_nxt    = ST_BUSY;
            end
            ST_BUSY: begin
                if (mul_op_done || wd_expired) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Clearing on the handshake leaves the core in INIT for the next op.
                if (resp_ready) begin
                    mul_op_clear = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Accept: capture operands, owner tag and advance the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr           <= 1'b0;
            resp_id          <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else if (state == ST_IDLE && req_fire) begin
            rr_ptr           <= ~gnt_id;
            resp_id          <= gnt_id;
            mul_multiplier   <= gnt_id ? req_multiplier[2*OP_W-1:OP_W]
                                       : req_multiplier[OP_W-1:0];
            mul_multiplicand <= gnt_id ? req_multiplicand[2*OP_W-1:OP_W]
                                       : req_multiplicand[OP_W-1:0];
        end
    end

    // Watchdog: zeroed as the core starts, counts each cycle spent waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                wd_cnt <= '0;
        else if (state == ST_START)  wd_cnt <= '0;
        else if (state == ST_BUSY)   wd_cnt <= wd_cnt + CNT_W'(1);
    end

    // Response capture; a completing core beats a simultaneous timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_result <= '0;
            resp_error  <= 1'b0;
        end else if (state == ST_BUSY) begin
            if (mul_op_done) begin
                resp_result <= mul_result;
                resp_error  <= 1'b0;
            end else if (wd_expired) begin
                resp_result <= '0;
                resp_error  <= 1'b1;
            end
        end
    end

endmodule
